// File: rtl/pixel_packer.sv
// pixel_packer: packs RGB888 pixels (4 per group) into three 32-bit AXI4-Stream words with SOF/EOL markers.
// Optional internal test-pattern source enabled by defining PIXEL_PACKER_TEST_PATTERN_EN.
module pixel_packer #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
) (
    input  logic        aclk,
    input  logic        aresetn,
`ifdef PIXEL_PACKER_TEST_PATTERN_EN
    input  logic        test_en,
`endif
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_tdata,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic        out_tlast,
    output logic        out_tuser
);

    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    logic [1:0]    r_phase;
    logic [23:0]   r_res;
    logic [XW-1:0] r_x_cnt;
    logic [YW-1:0] r_y_cnt;
    logic          r_sof;
    logic [31:0]   r_tdata;
    logic          r_tvalid;
    logic          r_tlast;
    logic          r_tuser;

    logic          w_valid;
    logic          w_can;
    logic          w_acc;
    logic [7:0]    w_r;
    logic [7:0]    w_g;
    logic [7:0]    w_b;
    logic [31:0]   w_word;
    logic [23:0]   w_res_nxt;
    logic          w_x_last;
    logic          w_y_last;

    // A phase-0 pixel only fills the residue, so it never waits on the output register.
    assign w_can = (r_phase == 2'd0) || !r_tvalid || out_tready;

`ifdef PIXEL_PACKER_TEST_PATTERN_EN
    assign w_valid  = test_en | in_valid;
    assign w_r      = test_en ? 8'(r_x_cnt) : in_r;
    assign w_g      = test_en ? 8'(r_y_cnt) : in_g;
    assign w_b      = test_en ? 8'hA5 : in_b;
    assign in_ready = aresetn && w_can && !test_en;
`else
    assign w_valid  = in_valid;
    assign w_r      = in_r;
    assign w_g      = in_g;
    assign w_b      = in_b;
    assign in_ready = aresetn && w_can;
`endif

    assign w_acc    = w_valid && w_can;
    assign w_x_last = (r_x_cnt == X_LAST);
    assign w_y_last = (r_y_cnt == Y_LAST);

    // Byte steering: completed word and carried-over residue for the current phase.
    always_comb begin
        w_word    = 32'd0;
        w_res_nxt = 24'd0;
        case (r_phase)
            2'd0: w_res_nxt = {w_b, w_g, w_r};
            2'd1: begin
                w_word    = {w_r, r_res};
                w_res_nxt = {8'd0, w_b, w_g};
            end
            2'd2: begin
                w_word    = {w_g, w_r, r_res[15:0]};
                w_res_nxt = {16'd0, w_b};
            end
            2'd3: w_word = {w_b, w_g, w_r, r_res[7:0]};
            default: begin
                w_word    = 32'd0;
                w_res_nxt = 24'd0;
            end
        endcase
    end

    // Phase, residue and pixel position tracking.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_phase <= 2'd0;
            r_res   <= 24'd0;
            r_x_cnt <= '0;
            r_y_cnt <= '0;
            r_sof   <= 1'b0;
        end else if (w_acc) begin
            r_phase <= r_phase + 2'd1;
            r_res   <= w_res_nxt;
            if (r_phase == 2'd0) begin
                r_sof <= (r_x_cnt == '0) && (r_y_cnt == '0);
            end
            if (w_x_last) begin
                r_x_cnt <= '0;
                r_y_cnt <= w_y_last ? '0 : r_y_cnt + 1'b1;
            end else begin
                r_x_cnt <= r_x_cnt + 1'b1;
            end
        end
    end

    // Single-entry output register; contents hold while the sink stalls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tdata  <= 32'd0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tuser  <= 1'b0;
        end else if (w_acc && (r_phase != 2'd0)) begin
            r_tdata  <= w_word;
            r_tvalid <= 1'b1;
            r_tlast  <= (r_phase == 2'd3) && w_x_last;
            r_tuser  <= (r_phase == 2'd1) && r_sof;
        end else if (out_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign out_tdata  = r_tdata;
    assign out_tvalid = r_tvalid;
    assign out_tlast  = r_tlast;
    assign out_tuser  = r_tuser;

endmodule

// File: tb/tb_pixel_packer.sv
// Directed self-checking bench for pixel_packer (X_SIZE=8, Y_SIZE=2); words are logged at the sink handshake.
module tb_pixel_packer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic [7:0]  in_r = 8'd0;
    logic [7:0]  in_g = 8'd0;
    logic [7:0]  in_b = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_tdata;
    logic        out_tvalid;
    logic        out_tready = 1'b1;
    logic        out_tlast;
    logic        out_tuser;
`ifdef PIXEL_PACKER_TEST_PATTERN_EN
    logic        test_en = 1'b0;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int n_stall = 0;
    logic [33:0] q[$];

    pixel_packer #(.X_SIZE(8), .Y_SIZE(2)) dut (
        .aclk(aclk),
        .aresetn(aresetn),
`ifdef PIXEL_PACKER_TEST_PATTERN_EN
        .test_en(test_en),
`endif
        .in_r(in_r),
        .in_g(in_g),
        .in_b(in_b),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_tdata(out_tdata),
        .out_tvalid(out_tvalid),
        .out_tready(out_tready),
        .out_tlast(out_tlast),
        .out_tuser(out_tuser)
    );

    always #5 aclk = ~aclk;

    // Sink monitor: inputs change just after posedge, so negedge values equal those at the next edge.
    always @(negedge aclk) begin
        if (aresetn && out_tvalid && out_tready) q.push_back({out_tuser, out_tlast, out_tdata});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input int k, input logic [33:0] exp);
        if (q.size() > k) chk(tag, 64'(q[k]), 64'(exp));
        else chk({tag, "_missing"}, 64'(q.size()), 64'(k + 1));
    endtask

    task automatic push_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int t = 0;
        in_r = r; in_g = g; in_b = b; in_valid = 1'b1;
        @(negedge aclk);
        while (!in_ready && t < 50) begin
            t++;
            @(negedge aclk);
        end
        n_stall += t;
        if (t >= 50) chk("push_timeout", 64'(t), 64'd0);
        @(posedge aclk); #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        q.delete();
    endtask

    initial begin
        int errs;
        int errs2;
        logic [7:0] b0;
        logic [33:0] w;

        // Reset state
        #1 aresetn = 1'b0;
        #2;
        chk("rst_tvalid", 64'(out_tvalid), 64'd0);
        chk("rst_tdata",  64'(out_tdata),  64'd0);
        chk("rst_tlast",  64'(out_tlast),  64'd0);
        chk("rst_tuser",  64'(out_tuser),  64'd0);
        chk("rst_ready",  64'(in_ready),   64'd0);
        do_reset();

        // First group
        push_px(8'h01, 8'h02, 8'h03);
        push_px(8'h04, 8'h05, 8'h06);
        push_px(8'h07, 8'h08, 8'h09);
        push_px(8'h0A, 8'h0B, 8'h0C);
        in_valid = 1'b0;
        repeat (3) @(posedge aclk); #1;
        chk("g1_count", 64'(q.size()), 64'd3);
        chk_word("g1_w0", 0, {1'b1, 1'b0, 32'h04030201});
        chk_word("g1_w1", 1, {1'b0, 1'b0, 32'h08070605});
        chk_word("g1_w2", 2, {1'b0, 1'b0, 32'h0C0B0A09});

        // Frame markers: 20 pixels -> 15 words; byte n carries value n+1
        do_reset();
        n_stall = 0;
        for (int i = 0; i < 20; i++) push_px(8'(3*i+1), 8'(3*i+2), 8'(3*i+3));
        in_valid = 1'b0;
        repeat (3) @(posedge aclk); #1;
        chk("fr_count", 64'(q.size()), 64'd15);
        chk("fr_stall", 64'(n_stall), 64'd0);
        for (int k = 0; k < 15; k++) begin
            b0 = 8'(4*k+1);
            w = {(k % 12 == 0), (k % 6 == 5), b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
            chk_word($sformatf("fr_w%0d", k), k, w);
        end

        // Full rate: 400 accepts, out_tvalid after pixel i is 1 unless i%4==0
        do_reset();
        n_stall = 0;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            push_px(8'(i), 8'(i+1), 8'(i+2));
            if (out_tvalid !== ((i % 4) != 0)) errs++;
        end
        in_valid = 1'b0;
        chk("fullrate_stall", 64'(n_stall), 64'd0);
        chk("fullrate_tvalid_pattern", 64'(errs), 64'd0);

        // Backpressure
        do_reset();
        out_tready = 1'b0;
        push_px(8'h11, 8'h12, 8'h13);
        push_px(8'h14, 8'h15, 8'h16);
        in_r = 8'h17; in_g = 8'h18; in_b = 8'h19; in_valid = 1'b1;
        errs = 0;
        errs2 = 0;
        repeat (6) begin
            @(negedge aclk);
            if (in_ready !== 1'b0) errs++;
            if (out_tvalid !== 1'b1 || out_tdata !== 32'h14131211 || out_tuser !== 1'b1) errs2++;
        end
        chk("bp_ready_low", 64'(errs), 64'd0);
        chk("bp_hold", 64'(errs2), 64'd0);
        @(posedge aclk); #1;
        out_tready = 1'b1;
        push_px(8'h17, 8'h18, 8'h19);
        push_px(8'h1A, 8'h1B, 8'h1C);
        in_valid = 1'b0;
        repeat (3) @(posedge aclk); #1;
        chk("bp_count", 64'(q.size()), 64'd3);
        chk_word("bp_w0", 0, {1'b1, 1'b0, 32'h14131211});
        chk_word("bp_w1", 1, {1'b0, 1'b0, 32'h18171615});
        chk_word("bp_w2", 2, {1'b0, 1'b0, 32'h1C1B1A19});

        // Reset mid-line at phase 2
        do_reset();
        for (int i = 0; i < 6; i++) push_px(8'(i), 8'(i), 8'(i));
        in_valid = 1'b0;
        chk("mid_tvalid_pre", 64'(out_tvalid), 64'd1);
        aresetn = 1'b0;
        #1;
        chk("mid_tvalid_async", 64'(out_tvalid), 64'd0);
        chk("mid_ready_async", 64'(in_ready), 64'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        q.delete();
        push_px(8'h21, 8'h22, 8'h23);
        push_px(8'h24, 8'h25, 8'h26);
        push_px(8'h27, 8'h28, 8'h29);
        push_px(8'h2A, 8'h2B, 8'h2C);
        in_valid = 1'b0;
        repeat (3) @(posedge aclk); #1;
        chk("mid_count", 64'(q.size()), 64'd3);
        chk_word("mid_w0", 0, {1'b1, 1'b0, 32'h24232221});
        chk_word("mid_w2", 2, {1'b0, 1'b0, 32'h2C2B2A29});

`ifdef PIXEL_PACKER_TEST_PATTERN_EN
        // Internal test pattern
        do_reset();
        test_en = 1'b1;
        errs = 0;
        for (int t = 0; t < 20 && q.size() == 0; t++) begin
            @(negedge aclk);
            if (in_ready !== 1'b0) errs++;
        end
        chk("tp_ready_low", 64'(errs), 64'd0);
        chk_word("tp_w0", 0, {1'b1, 1'b0, 32'h01A50000});
        @(posedge aclk); #1;
        aresetn = 1'b0;
        test_en = 1'b0;
        #1 aresetn = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
